// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_arb_pkg -- default widths and FSM state encoding for the
// mem_port_arbiter slice.                                  Rev 1.0
// ------------------------------------------------------------------
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // State enumeration, kept as plain 2-bit constants for legacy tools
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_ISSUE = 2'd1;
  localparam arb_state_t ST_RESP  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mem_arb_select.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_arb_select -- 2-way grant logic and priority pointer.
// MEM_ARB_ROUND_ROBIN_EN: defined = round-robin, undefined = r1 fixed
// priority.                                                Rev 1.0
// ------------------------------------------------------------------
module mem_arb_select (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic arb_en,
  output logic gnt0,
  output logic gnt1
);

  logic prefer_r1;
  logic pick_r1;

  // r1 wins when alone or when the pointer favours it on contention
  assign pick_r1 = req1 & (~req0 | prefer_r1);
  assign gnt1    = arb_en & pick_r1;
  assign gnt0    = arb_en & req0 & ~pick_r1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prefer_r1 <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    end else if (gnt0 | gnt1) begin
      prefer_r1 <= gnt0;
`else
    end else begin
      prefer_r1 <= 1'b1;
`endif
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_port_arbiter -- two-requester single-port memory arbiter.
// Policy set by MEM_ARB_ROUND_ROBIN_EN (see mem_arb_select). Rev 1.0
// ------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_writeEn,
  output logic              mem_readEn,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_dataIn,
  input  logic [DATA_W-1:0] mem_dataOut
);

  arb_state_t        state;
  logic              owner;
  logic              arb_en;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] r0_rdata_q;
  logic [DATA_W-1:0] r1_rdata_q;

  // Grants are gated by rst_n so every output reads 0 while reset is held
  assign arb_en = rst_n & (state == ST_IDLE);

  mem_arb_select u_select (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (r0_req),
    .req1   (r1_req),
    .arb_en (arb_en),
    .gnt0   (r0_gnt),
    .gnt1   (r1_gnt)
  );

  assign any_gnt   = r0_gnt | r1_gnt;
  assign sel_we    = r1_gnt ? r1_we    : r0_we;
  assign sel_addr  = r1_gnt ? r1_addr  : r0_addr;
  assign sel_wdata = r1_gnt ? r1_wdata : r0_wdata;

  // Strobes and address/data are loaded at the grant edge, so they are
  // high for exactly the ISSUE cycle and hold their value afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      owner       <= 1'b0;
      mem_readEn  <= 1'b0;
      mem_writeEn <= 1'b0;
      mem_address <= '0;
      mem_dataIn  <= '0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_gnt) begin
            owner       <= r1_gnt;
            mem_readEn  <= ~sel_we;
            mem_writeEn <= sel_we;
            mem_address <= sel_addr;
            mem_dataIn  <= sel_wdata;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_readEn  <= 1'b0;
          mem_writeEn <= 1'b0;
          state       <= mem_writeEn ? ST_IDLE : ST_RESP;
        end
        ST_RESP: begin
          if (owner) r1_rdata_q <= mem_dataOut;
          else       r0_rdata_q <= mem_dataOut;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign r0_rvalid = (state == ST_RESP) & ~owner;
  assign r1_rvalid = (state == ST_RESP) &  owner;
  assign r0_rdata  = r0_rvalid ? mem_dataOut : r0_rdata_q;
  assign r1_rdata  = r1_rvalid ? mem_dataOut : r1_rdata_q;

endmodule
`default_nettype wire
